// File: rtl/pa_core_top.sv
// pa_core_top: in-order multicycle 32-bit core with direct-mapped I$/D$ and one tagged miss-response channel.
// Build option: define CORE_MUL_EN to include the MUL instruction; otherwise opcode 0x02 traps.
module pa_core_top (
    input  logic         clock,
    input  logic         reset,
    input  logic [31:0]  boot_addr,
    input  logic [31:0]  xcpt_addr,
    output logic         icache_req_valid_miss,
    output logic [156:0] icache_req_info_miss,
    output logic         dcache_req_valid_miss,
    output logic [156:0] dcache_req_info_miss,
    input  logic         rsp_valid_miss,
    input  logic [127:0] rsp_data_miss,
    input  logic         rsp_cache_id
);
    localparam int LINE_W    = 128;
    localparam int NUM_LINES = 4;
    localparam int NUM_REGS  = 32;
    localparam int WORD_W    = 32;

    localparam logic [6:0] OPC_ADD  = 7'h00;
    localparam logic [6:0] OPC_SUB  = 7'h01;
    localparam logic [6:0] OPC_MUL  = 7'h02;
    localparam logic [6:0] OPC_LDW  = 7'h11;
    localparam logic [6:0] OPC_STW  = 7'h13;
    localparam logic [6:0] OPC_BEQ  = 7'h30;
    localparam logic [6:0] OPC_JUMP = 7'h31;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IMISS = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_DMISS = 3'd4,
        S_SWAIT = 3'd5
    } state_t;

    state_t            state_r, state_s;
    logic [31:0]       pc_r, pc_nxt_s, pc_plus4_s, instr_r;
    logic [31:2]       ea_r;
    logic              pc_we_s, instr_ld_s, ea_ld_s;
    logic [31:0]       regs_r [NUM_REGS];
    logic              reg_we_s;
    logic [31:0]       reg_wdata_s;

    logic [LINE_W-1:0] ic_data_r [NUM_LINES];
    logic [31:6]       ic_tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0] ic_valid_r;
    logic [LINE_W-1:0] dc_data_r [NUM_LINES];
    logic [31:6]       dc_tag_r  [NUM_LINES];
    logic [NUM_LINES-1:0] dc_valid_r;

    logic              ic_fill_s, dc_fill_s, dc_merge_s;
    logic              ireq_s, dreq_s, dreq_store_s;
    logic              rsp_i_s, rsp_d_s, ic_hit_s, dc_hit_s;
    logic [31:0]       ic_word_s, ld_word_s;
    logic [LINE_W-1:0] dc_line_s, merged_s;

    logic [6:0]        opc_s;
    logic [4:0]        rd_s, ra_s, rb_s;
    logic [31:0]       imm_s, rd_val_s, ra_val_s, rb_val_s, ea_s;

    assign opc_s    = instr_r[31:25];
    assign rd_s     = instr_r[24:20];
    assign ra_s     = instr_r[19:15];
    assign rb_s     = instr_r[14:10];
    assign imm_s    = {{17{instr_r[14]}}, instr_r[14:0]};
    assign rd_val_s = regs_r[rd_s];
    assign ra_val_s = regs_r[ra_s];
    assign rb_val_s = regs_r[rb_s];
    assign ea_s     = ra_val_s + imm_s;
    assign pc_plus4_s = pc_r + 32'd4;

`ifdef CORE_MUL_EN
    logic [31:0] mul_s;
    assign mul_s = ra_val_s * rb_val_s;
`endif

    assign rsp_i_s   = rsp_valid_miss & ~rsp_cache_id;
    assign rsp_d_s   = rsp_valid_miss &  rsp_cache_id;
    assign ic_hit_s  = ic_valid_r[pc_r[5:4]] && (ic_tag_r[pc_r[5:4]] == pc_r[31:6]);
    assign ic_word_s = ic_data_r[pc_r[5:4]][{pc_r[3:2], 5'd0} +: WORD_W];
    assign dc_hit_s  = dc_valid_r[ea_r[5:4]] && (dc_tag_r[ea_r[5:4]] == ea_r[31:6]);
    assign dc_line_s = dc_data_r[ea_r[5:4]];
    assign ld_word_s = dc_line_s[{ea_r[3:2], 5'd0} +: WORD_W];

    // Store data: the resident line with the addressed word replaced by r[rd].
    always_comb begin
        merged_s = dc_line_s;
        merged_s[{ea_r[3:2], 5'd0} +: WORD_W] = rd_val_s;
    end

    // Next-state and datapath control for the multicycle sequencer.
    always_comb begin
        state_s      = state_r;
        pc_we_s      = 1'b0;
        pc_nxt_s     = pc_plus4_s;
        instr_ld_s   = 1'b0;
        ea_ld_s      = 1'b0;
        reg_we_s     = 1'b0;
        reg_wdata_s  = ra_val_s + rb_val_s;
        ic_fill_s    = 1'b0;
        dc_fill_s    = 1'b0;
        dc_merge_s   = 1'b0;
        ireq_s       = 1'b0;
        dreq_s       = 1'b0;
        dreq_store_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (ic_hit_s) begin
                    instr_ld_s = 1'b1;
                    state_s    = S_EXEC;
                end else begin
                    ireq_s  = 1'b1;
                    state_s = S_IMISS;
                end
            end
            S_IMISS: begin
                if (rsp_i_s) begin
                    ic_fill_s = 1'b1;
                    state_s   = S_FETCH;
                end else begin
                    state_s = S_IMISS;
                end
            end
            S_EXEC: begin
                pc_we_s = 1'b1;
                state_s = S_FETCH;
                case (opc_s)
                    OPC_ADD: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = ra_val_s + rb_val_s;
                    end
                    OPC_SUB: begin
                        reg_we_s    = 1'b1;
                        reg_wdata_s = ra_val_s - rb_val_s;
                    end
                    OPC_MUL: begin
`ifdef CORE_MUL_EN
                        reg_we_s    = 1'b1;
                        reg_wdata_s = mul_s;
`else
                        pc_nxt_s    = xcpt_addr;
`endif
                    end
                    OPC_LDW, OPC_STW: begin
                        if (ea_s[1:0] != 2'b00) begin
                            pc_nxt_s = xcpt_addr;
                        end else begin
                            pc_we_s = 1'b0;
                            ea_ld_s = 1'b1;
                            state_s = S_MEM;
                        end
                    end
                    OPC_BEQ: begin
                        if (rd_val_s == ra_val_s) begin
                            pc_nxt_s = pc_r + imm_s;
                        end else begin
                            pc_nxt_s = pc_plus4_s;
                        end
                    end
                    OPC_JUMP: pc_nxt_s = ea_s;
                    default:  pc_nxt_s = xcpt_addr;
                endcase
            end
            S_MEM: begin
                if (!dc_hit_s) begin
                    dreq_s  = 1'b1;
                    state_s = S_DMISS;
                end else if (opc_s == OPC_LDW) begin
                    reg_we_s    = 1'b1;
                    reg_wdata_s = ld_word_s;
                    pc_we_s     = 1'b1;
                    state_s     = S_FETCH;
                end else begin
                    dc_merge_s   = 1'b1;
                    dreq_s       = 1'b1;
                    dreq_store_s = 1'b1;
                    state_s      = S_SWAIT;
                end
            end
            S_DMISS: begin
                if (rsp_d_s) begin
                    dc_fill_s = 1'b1;
                    state_s   = S_MEM;
                end else begin
                    state_s = S_DMISS;
                end
            end
            S_SWAIT: begin
                if (rsp_d_s) begin
                    pc_we_s = 1'b1;
                    state_s = S_FETCH;
                end else begin
                    state_s = S_SWAIT;
                end
            end
            default: state_s = S_FETCH;
        endcase
    end

    // Sequencer state, PC and latched instruction/effective address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
            pc_r    <= boot_addr;
            instr_r <= 32'd0;
            ea_r    <= 30'd0;
        end else begin
            state_r <= state_s;
            if (pc_we_s)    pc_r    <= pc_nxt_s;
            if (instr_ld_s) instr_r <= ic_word_s;
            if (ea_ld_s)    ea_r    <= ea_s[31:2];
        end
    end

    // Register file; all registers are writable and cleared on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'd0;
        end else if (reg_we_s) begin
            regs_r[rd_s] <= reg_wdata_s;
        end
    end

    // Cache valid bits; I$ is never invalidated by stores.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ic_valid_r <= {NUM_LINES{1'b0}};
            dc_valid_r <= {NUM_LINES{1'b0}};
        end else begin
            if (ic_fill_s) ic_valid_r[pc_r[5:4]] <= 1'b1;
            if (dc_fill_s) dc_valid_r[ea_r[5:4]] <= 1'b1;
        end
    end

    // Cache data and tag arrays.
    always_ff @(posedge clock) begin
        if (ic_fill_s) begin
            ic_data_r[pc_r[5:4]] <= rsp_data_miss;
            ic_tag_r[pc_r[5:4]]  <= pc_r[31:6];
        end
        if (dc_fill_s) begin
            dc_data_r[ea_r[5:4]] <= rsp_data_miss;
            dc_tag_r[ea_r[5:4]]  <= ea_r[31:6];
        end else if (dc_merge_s) begin
            dc_data_r[ea_r[5:4]] <= merged_s;
        end
    end

    // Miss request outputs: one-cycle valid pulse, info held until the next request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            icache_req_valid_miss <= 1'b0;
            icache_req_info_miss  <= 157'd0;
            dcache_req_valid_miss <= 1'b0;
            dcache_req_info_miss  <= 157'd0;
        end else begin
            icache_req_valid_miss <= ireq_s;
            dcache_req_valid_miss <= dreq_s;
            if (ireq_s) icache_req_info_miss <= {pc_r[31:4], 1'b0, {LINE_W{1'b0}}};
            if (dreq_s) dcache_req_info_miss <= {ea_r[31:4], dreq_store_s,
                                                 dreq_store_s ? merged_s : {LINE_W{1'b0}}};
        end
    end
endmodule

// File: tb/tb_pa_core_top.sv
// Directed bench for pa_core_top: a line-addressed memory model serves misses; results are
// observed through write-through store requests.
module tb_pa_core_top;
    localparam logic [6:0] OPC_ADD  = 7'h00;
    localparam logic [6:0] OPC_SUB  = 7'h01;
    localparam logic [6:0] OPC_MUL  = 7'h02;
    localparam logic [6:0] OPC_LDW  = 7'h11;
    localparam logic [6:0] OPC_STW  = 7'h13;
    localparam logic [6:0] OPC_BEQ  = 7'h30;
    localparam logic [6:0] OPC_JUMP = 7'h31;
`ifdef CORE_MUL_EN
    localparam bit MUL_X = 1'b0;
`else
    localparam bit MUL_X = 1'b1;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  boot_addr = 32'h0000_1000;
    logic [31:0]  xcpt_addr = 32'h0000_2000;
    logic         icache_req_valid_miss, dcache_req_valid_miss;
    logic [156:0] icache_req_info_miss, dcache_req_info_miss;
    logic         rsp_valid_miss = 1'b0;
    logic [127:0] rsp_data_miss = 128'd0;
    logic         rsp_cache_id = 1'b0;

    always #5 clock = ~clock;

    pa_core_top dut (
        .clock(clock), .reset(reset), .boot_addr(boot_addr), .xcpt_addr(xcpt_addr),
        .icache_req_valid_miss(icache_req_valid_miss), .icache_req_info_miss(icache_req_info_miss),
        .dcache_req_valid_miss(dcache_req_valid_miss), .dcache_req_info_miss(dcache_req_info_miss),
        .rsp_valid_miss(rsp_valid_miss), .rsp_data_miss(rsp_data_miss), .rsp_cache_id(rsp_cache_id)
    );

    typedef struct { logic is_d; logic [156:0] info; } req_t;
    typedef struct { string name; logic [31:0] instr; logic [31:0] a; logic [31:0] b; bit xcpt; logic [31:0] val; } vec_t;

    logic [127:0] mem [0:1023];
    req_t log_q[$];
    vec_t vecs[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] ra, input logic [14:0] imm);
        return {opc, rd, ra, imm};
    endfunction

    function automatic logic [31:0] encr(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] ra, input logic [4:0] rb);
        return {opc, rd, ra, rb, 10'd0};
    endfunction

    task automatic put_word(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[13:4]][{addr[3:2], 5'd0} +: 32] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 128'd0;
    endtask

    function automatic logic [156:0] get_info(input int idx);
        if (idx < log_q.size()) return log_q[idx].info;
        else return 157'd0;
    endfunction

    task automatic do_reset(input logic [31:0] boot);
        @(negedge clock);
        reset = 1'b0;
        boot_addr = boot;
        rsp_valid_miss = 1'b0;
        log_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_req(input int budget, output logic found, output logic is_d, output logic [156:0] info);
        found = 1'b0; is_d = 1'b0; info = 157'd0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clock);
            if (icache_req_valid_miss || dcache_req_valid_miss) begin
                found = 1'b1;
                is_d  = dcache_req_valid_miss;
                info  = dcache_req_valid_miss ? dcache_req_info_miss : icache_req_info_miss;
            end
        end
    endtask

    task automatic respond(input logic id, input logic [127:0] data);
        rsp_valid_miss = 1'b1; rsp_cache_id = id; rsp_data_miss = data;
        @(negedge clock);
        rsp_valid_miss = 1'b0;
    endtask

    // Serve every miss from mem (stores update mem) until n_stores stores are seen.
    task automatic run(input string name, input int n_stores, input int budget);
        int seen = 0;
        logic d;
        logic [156:0] inf;
        for (int c = 0; c < budget && seen < n_stores; c++) begin
            @(negedge clock);
            rsp_valid_miss = 1'b0;
            if (icache_req_valid_miss || dcache_req_valid_miss) begin
                d   = dcache_req_valid_miss;
                inf = d ? dcache_req_info_miss : icache_req_info_miss;
                log_q.push_back('{d, inf});
                if (inf[128]) begin
                    mem[inf[138:129]] = inf[127:0];
                    seen++;
                end
                rsp_valid_miss = 1'b1; rsp_cache_id = d; rsp_data_miss = mem[inf[138:129]];
            end
        end
        @(negedge clock);
        rsp_valid_miss = 1'b0;
        check({name, "_stores"}, 160'(seen), 160'(n_stores));
    endtask

    task automatic add_vec(input string n, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input bit x, input logic [31:0] v);
        vec_t t;
        t.name = n; t.instr = ins; t.a = a; t.b = b; t.xcpt = x; t.val = v;
        vecs.push_back(t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found, is_d;
        logic [156:0] info;
        int ireqs;
        logic [127:0] exp_line;

        // Cold boot, reset state, first I$ pulse and line reuse.
        clear_mem();
        repeat (3) @(negedge clock);
        check("rst_valids", 160'({icache_req_valid_miss, dcache_req_valid_miss}), 160'(2'b00));
        check("rst_infos", 160'(icache_req_info_miss | dcache_req_info_miss), 160'd0);
        reset = 1'b1;
        wait_req(20, found, is_d, info);
        check("boot_ireq", 160'({found, is_d, info}), 160'({1'b1, 1'b0, 28'h0000100, 1'b0, 128'd0}));
        rsp_valid_miss = 1'b1; rsp_cache_id = 1'b0; rsp_data_miss = mem[10'h100];
        @(negedge clock);
        rsp_valid_miss = 1'b0;
        check("boot_pulse_width", 160'({icache_req_valid_miss, dcache_req_valid_miss}), 160'(2'b00));
        wait_req(40, found, is_d, info);
        check("boot_next_line", 160'({found, is_d, info[156:129]}), 160'({1'b1, 1'b0, 28'h0000101}));

        // Reset while that miss is outstanding: outputs drop at once, restart at new boot_addr.
        reset = 1'b0;
        #1;
        check("midmiss_valids", 160'({icache_req_valid_miss, dcache_req_valid_miss}), 160'(2'b00));
        check("midmiss_infos", 160'(icache_req_info_miss | dcache_req_info_miss), 160'd0);
        @(negedge clock);
        boot_addr = 32'h0000_1400;
        @(negedge clock);
        reset = 1'b1;
        wait_req(20, found, is_d, info);
        check("midmiss_restart", 160'({found, is_d, info[156:128]}), 160'({1'b1, 1'b0, 28'h0000140, 1'b0}));

        // ALU / load / exception vectors: r1=a, r2=b, op, STW r3 -> 0x808; handler stores r3 -> 0x80C.
        add_vec("add",      encr(OPC_ADD, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b0, 32'd12);
        add_vec("sub",      encr(OPC_SUB, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE);
        add_vec("add_wrap", encr(OPC_ADD, 5'd3, 5'd1, 5'd2), 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0);
        add_vec("sub_rdra", encr(OPC_SUB, 5'd3, 5'd3, 5'd2), 32'd5, 32'd7, 1'b0, 32'hFFFF_FFF9);
        add_vec("mul_big",  encr(OPC_MUL, 5'd3, 5'd1, 5'd2), 32'h0001_0000, 32'h0001_0000, MUL_X, 32'd0);
        add_vec("mul_small",encr(OPC_MUL, 5'd3, 5'd1, 5'd2), 32'd6, 32'd7, MUL_X, 32'd42);
        add_vec("opc_7f",   encr(7'h7F, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b1, 32'd0);
        add_vec("opc_12",   encr(7'h12, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 1'b1, 32'd0);
        add_vec("ldw_unal", enc(OPC_LDW, 5'd3, 5'd0, 15'h2002), 32'd5, 32'd7, 1'b1, 32'd0);
        add_vec("ldw_hit",  enc(OPC_LDW, 5'd3, 5'd0, 15'h080C), 32'd5, 32'd7, 1'b0, 32'h6666_6666);
        for (int i = 0; i < vecs.size(); i++) begin
            clear_mem();
            put_word(32'h1000, enc(OPC_LDW, 5'd1, 5'd0, 15'h0800));
            put_word(32'h1004, enc(OPC_LDW, 5'd2, 5'd0, 15'h0804));
            put_word(32'h1008, vecs[i].instr);
            put_word(32'h100C, enc(OPC_STW, 5'd3, 5'd0, 15'h0808));
            put_word(32'h2000, enc(OPC_STW, 5'd3, 5'd0, 15'h080C));
            mem[10'h080] = {32'h6666_6666, 32'h5555_5555, vecs[i].b, vecs[i].a};
            do_reset(32'h0000_1000);
            run(vecs[i].name, 1, 400);
            ireqs = 0;
            foreach (log_q[k]) if (!log_q[k].is_d) ireqs++;
            check({vecs[i].name, "_ireqs"}, 160'(ireqs), 160'(vecs[i].xcpt ? 2 : 1));
            exp_line = vecs[i].xcpt ? {32'd0, 32'h5555_5555, vecs[i].b, vecs[i].a}
                                    : {32'h6666_6666, vecs[i].val, vecs[i].b, vecs[i].a};
            check({vecs[i].name, "_line"}, 160'(get_info(log_q.size() - 1)), 160'({28'h0000080, 1'b1, exp_line}));
        end

        // BEQ at 0x1010, imm -8: taken -> 0x1008 (STW to word 2), not taken -> 0x1014 (STW to word 3).
        for (int t = 0; t < 2; t++) begin
            clear_mem();
            put_word(32'h1000, enc(OPC_LDW, 5'd1, 5'd0, 15'h0800));
            put_word(32'h1004, enc(OPC_JUMP, 5'd0, 5'd0, 15'h1010));
            put_word(32'h1008, enc(OPC_STW, 5'd1, 5'd0, 15'h0808));
            put_word(32'h1010, enc(OPC_BEQ, 5'd1, (t == 0) ? 5'd1 : 5'd2, 15'h7FF8));
            put_word(32'h1014, enc(OPC_STW, 5'd1, 5'd0, 15'h080C));
            mem[10'h080] = {32'h6666_6666, 32'h5555_5555, 32'd0, 32'd5};
            do_reset(32'h0000_1000);
            run((t == 0) ? "beq_taken" : "beq_not", 1, 400);
            exp_line = (t == 0) ? {32'h6666_6666, 32'd5, 32'd0, 32'd5} : {32'd5, 32'h5555_5555, 32'd0, 32'd5};
            check((t == 0) ? "beq_taken_line" : "beq_not_line", 160'(get_info(log_q.size() - 1)), 160'({28'h0000080, 1'b1, exp_line}));
        end

        // Cold STW to 0x2004: line load then write-through; following LDW hits.
        clear_mem();
        put_word(32'h1000, enc(OPC_LDW, 5'd4, 5'd0, 15'h0810));
        put_word(32'h1004, enc(OPC_STW, 5'd4, 5'd0, 15'h2004));
        put_word(32'h1008, enc(OPC_LDW, 5'd5, 5'd0, 15'h2004));
        put_word(32'h100C, enc(OPC_STW, 5'd5, 5'd0, 15'h0818));
        put_word(32'h0810, 32'hDEAD_BEEF);
        mem[10'h200] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        do_reset(32'h0000_1000);
        run("stw", 2, 600);
        check("stw_nreq", 160'(log_q.size()), 160'd5);
        check("stw_dload", 160'({log_q.size() > 2 ? log_q[2].is_d : 1'b0, get_info(2)}), 160'({1'b1, 28'h0000200, 1'b0, 128'd0}));
        check("stw_dstore", 160'(get_info(3)), 160'({28'h0000200, 1'b1, 32'hA3, 32'hA2, 32'hDEAD_BEEF, 32'hA0}));
        check("stw_ldw_back", 160'(get_info(4)), 160'({28'h0000081, 1'b1, 32'd0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF}));

        // Late I$ response while D$ miss outstanding must be ignored.
        clear_mem();
        put_word(32'h1000, enc(OPC_LDW, 5'd1, 5'd0, 15'h0800));
        put_word(32'h1004, enc(OPC_STW, 5'd1, 5'd0, 15'h0808));
        put_word(32'h0800, 32'h1234_5678);
        do_reset(32'h0000_1000);
        wait_req(20, found, is_d, info);
        respond(1'b0, mem[10'h100]);
        wait_req(20, found, is_d, info);
        check("ilv_dreq", 160'({found, is_d, info[156:128]}), 160'({1'b1, 1'b1, 28'h0000080, 1'b0}));
        respond(1'b0, {4{32'hBAD0_BAD0}});
        wait_req(6, found, is_d, info);
        check("ilv_still_waiting", 160'(found), 160'(1'b0));
        respond(1'b1, mem[10'h080]);
        run("ilv", 1, 200);
        check("ilv_line", 160'(get_info(log_q.size() - 1)), 160'({28'h0000080, 1'b1, 32'd0, 32'h1234_5678, 32'd0, 32'h1234_5678}));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
